// File: rtl/cw_capture_ctrl.sv
// Capture sequencer for the signal-watcher trace buffer: pre-trigger fill, masked compare trigger,
// post-trigger count. Define CW_EDGE_TRIG_EN to trigger on a rising edge of the compare instead of its level.
module cw_capture_ctrl #(
    parameter int DIN_WIDTH  = 7,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                  trig_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DIN_WIDTH-1:0]  trig_mask,
    input  logic [DIN_WIDTH-1:0]  trig_val,
    input  logic [ADDR_WIDTH-1:0] pre_len,
    input  logic [ADDR_WIDTH-1:0] post_len,
    input  logic [DIN_WIDTH-1:0]  bus_din,
    output logic                  wt_ce,
    output logic                  wt_en,
    output logic [ADDR_WIDTH-1:0] wt_addr,
    output logic [DIN_WIDTH-1:0]  wt_data,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] pre_q, pre_d;
    logic [ADDR_WIDTH-1:0] post_q, post_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DIN_WIDTH-1:0]  data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  trig_q, trig_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] taddr_q, taddr_d;

    logic [ADDR_WIDTH-1:0] pre_clamp;
    logic [ADDR_WIDTH-1:0] post_clamp;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  match;
    logic                  fire;
    logic                  capturing;

    assign pre_clamp  = (pre_len  > ADDR_MASK) ? ADDR_MASK : pre_len;
    assign post_clamp = (post_len > ADDR_MASK) ? ADDR_MASK : post_len;
    assign next_addr  = (addr_q + 1'b1) & ADDR_MASK;
    assign capturing  = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);

    // The compare looks at the sample currently presented to the RAM, so trig_addr is simply addr_q.
    assign match = (((data_q ^ trig_val) & trig_mask) == '0);

`ifdef CW_EDGE_TRIG_EN
    logic prev_q, prev_d;
    assign fire = match && !prev_q;
`else
    assign fire = match;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        post_d  = post_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        busy_d  = busy_q;
        trig_d  = trig_q;
        done_d  = done_q;
        taddr_d = taddr_q;
`ifdef CW_EDGE_TRIG_EN
        prev_d  = prev_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    pre_d   = pre_clamp;
                    post_d  = post_clamp;
                    state_d = (pre_clamp != '0) ? S_PRE : S_ARMED;
                    cnt_d   = '0;
                    wr_d    = 1'b1;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    trig_d  = 1'b0;
                    taddr_d = '0;
`ifdef CW_EDGE_TRIG_EN
                    prev_d  = 1'b0;
`endif
                end
            end
            S_PRE: begin
                wr_d   = 1'b1;
                addr_d = next_addr;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == pre_q - 1'b1) begin
                    state_d = S_ARMED;
                    cnt_d   = '0;
`ifdef CW_EDGE_TRIG_EN
                    prev_d  = 1'b0;
`endif
                end
            end
            S_ARMED: begin
                wr_d   = 1'b1;
                addr_d = next_addr;
`ifdef CW_EDGE_TRIG_EN
                prev_d = match;
`endif
                if (fire) begin
                    trig_d  = 1'b1;
                    taddr_d = addr_q;
                    cnt_d   = '0;
                    if (post_q == '0) begin
                        state_d = S_DONE;
                        wr_d    = 1'b0;
                        addr_d  = addr_q;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_POST;
                    end
                end
            end
            S_POST: begin
                wr_d   = 1'b1;
                addr_d = next_addr;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == post_q - 1'b1) begin
                    state_d = S_DONE;
                    wr_d    = 1'b0;
                    addr_d  = addr_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything decided above, including a trigger in the same cycle.
        if (capturing && abort) begin
            state_d = S_IDLE;
            wr_d    = 1'b0;
            addr_d  = addr_q;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            trig_d  = trig_q;
            taddr_d = taddr_q;
        end

        data_d = wr_d ? bus_din : data_q;
    end

    always_ff @(posedge trig_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            post_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            taddr_q <= '0;
`ifdef CW_EDGE_TRIG_EN
            prev_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            post_q  <= post_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
            taddr_q <= taddr_d;
`ifdef CW_EDGE_TRIG_EN
            prev_q  <= prev_d;
`endif
        end
    end

    assign wt_ce     = wr_q;
    assign wt_en     = wr_q;
    assign wt_addr   = addr_q;
    assign wt_data   = data_q;
    assign busy      = busy_q;
    assign triggered = trig_q;
    assign done      = done_q;
    assign trig_addr = taddr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cw_capture_ctrl.sv
// Bench for cw_capture_ctrl: per-capture write sequence predicted from the stimulus table and
// checked write by write against the trace RAM interface, plus end-of-capture status checks.
module tb_cw_capture_ctrl;

    localparam int DW    = 7;
    localparam int AW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [DW-1:0] trig_mask;
    logic [DW-1:0] trig_val;
    logic [AW-1:0] pre_len;
    logic [AW-1:0] post_len;
    logic [DW-1:0] bus_din;
    logic          wt_ce;
    logic          wt_en;
    logic [AW-1:0] wt_addr;
    logic [DW-1:0] wt_data;
    logic          busy;
    logic          triggered;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_exp;
    logic [DW-1:0]    seq[64];

    cw_capture_ctrl #(.DIN_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .trig_clk (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .trig_mask(trig_mask),
        .trig_val (trig_val),
        .pre_len  (pre_len),
        .post_len (post_len),
        .bus_din  (bus_din),
        .wt_ce    (wt_ce),
        .wt_en    (wt_en),
        .wt_addr  (wt_addr),
        .wt_data  (wt_data),
        .busy     (busy),
        .triggered(triggered),
        .done     (done),
        .trig_addr(trig_addr),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (wt_en === 1'b1 || wt_ce === 1'b1) begin
            check_eq("ce_en_pair", {31'b0, wt_ce}, {31'b0, wt_en});
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_write", {31'b0, wt_en}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("write_addr_data", {9'b0, wt_addr, wt_data}, {9'b0, mon_exp});
            end
        end
    end

    // kill_kind: 0 = run to DONE, 1 = abort, 2 = reset; asserted while write #kill_at is on the bus.
    task automatic run_capture(input int pre, input int post, input logic [DW-1:0] mask,
                               input logic [DW-1:0] val, input int kill_kind, input int kill_at,
                               input int restart_k);
        int  pre_e, post_e, t, last, k_end;
        bit  m, prev;
        logic [AW-1:0] a;
        pre_e  = (pre  > DEPTH - 1) ? DEPTH - 1 : pre;
        post_e = (post > DEPTH - 1) ? DEPTH - 1 : post;
        t    = 63;
        prev = 1'b0;
        for (int k = pre_e; k < 64; k++) begin
            m = (((seq[k] ^ val) & mask) == '0);
`ifdef CW_EDGE_TRIG_EN
            if (m && !prev) begin t = k; break; end
`else
            if (m) begin t = k; break; end
`endif
            prev = m;
        end
        last  = t + post_e;
        k_end = (kill_kind != 0) ? kill_at + 1 : last + 1;
        for (int k = 0; k <= k_end - 1; k++) begin
            a = AW'(k % DEPTH);
            exp_q.push_back({a, seq[k]});
        end
        wr_cnt = 0;

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0;
        pre_len = AW'(pre); post_len = AW'(post);
        trig_mask = mask; trig_val = val;
        bus_din = seq[0];
        for (int k = 1; k <= k_end; k++) begin
            @(posedge clk); #1;
            start   = (k == restart_k);
            bus_din = (k < 64) ? seq[k] : '0;
            abort   = (kill_kind == 1) && (k == k_end);
            rst     = (kill_kind == 2) && (k == k_end);
            if (k == 1) begin
                @(negedge clk);
                check_eq("first_busy", {31'b0, busy}, 32'd1);
                check_eq("first_done_clr", {31'b0, done}, 32'd0);
                check_eq("first_trig_clr", {31'b0, triggered}, 32'd0);
                if (k_end > 1)
                    check_eq("first_state", {29'b0, dbg_state}, (pre_e > 0) ? 32'd1 : 32'd2);
            end
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        @(negedge clk);
        check_eq("no_write_after", {31'b0, wt_en}, 32'd0);
        check_eq("busy_after", {31'b0, busy}, 32'd0);
        check_eq("queue_drained", exp_q.size(), 32'd0);
        check_eq("write_count", wr_cnt, k_end);
        if (kill_kind == 0) begin
            check_eq("done", {31'b0, done}, 32'd1);
            check_eq("triggered", {31'b0, triggered}, 32'd1);
            check_eq("trig_addr", {16'b0, trig_addr}, t % DEPTH);
            check_eq("addr_hold", {16'b0, wt_addr}, last % DEPTH);
            check_eq("state_done", {29'b0, dbg_state}, 32'd4);
        end else if (kill_kind == 1) begin
            check_eq("abort_done", {31'b0, done}, 32'd0);
            check_eq("abort_trig", {31'b0, triggered}, (t < kill_at) ? 32'd1 : 32'd0);
            check_eq("abort_state", {29'b0, dbg_state}, 32'd0);
        end else begin
            check_eq("rst_done", {31'b0, done}, 32'd0);
            check_eq("rst_trig", {31'b0, triggered}, 32'd0);
            check_eq("rst_taddr", {16'b0, trig_addr}, 32'd0);
            check_eq("rst_addr", {16'b0, wt_addr}, 32'd0);
            check_eq("rst_state", {29'b0, dbg_state}, 32'd0);
        end
    endtask

    task automatic fill_seq(input logic [DW-1:0] v);
        for (int i = 0; i < 64; i++) seq[i] = v;
    endtask

    initial begin
        logic [DW-1:0] rm, rv;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        trig_mask = '0; trig_val = '0; pre_len = '0; post_len = '0; bus_din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", {9'b0, wt_ce, wt_en, busy, triggered, done, dbg_state},
                 32'd0);
        check_eq("reset_addrs", {wt_addr, trig_addr}, 32'd0);
        #1 rst = 1'b0;

        // Basic capture: trigger sample at index 6.
        fill_seq(7'h00); seq[6] = 7'h55;
        run_capture(4, 3, 7'h7F, 7'h55, 0, 0, -1);

        // Wrap-around from DONE, with a start pulse mid-capture that must be ignored.
        fill_seq(7'h00); seq[20] = 7'h2A;
        run_capture(0, 3, 7'h7F, 7'h2A, 0, 0, 5);

        // Immediate trigger, no post samples.
        for (int i = 0; i < 64; i++) seq[i] = DW'($urandom_range(127, 0));
        run_capture(0, 0, 7'h00, 7'h00, 0, 0, -1);

        // Abort two writes into POST.
        fill_seq(7'h00); seq[3] = 7'h11;
        run_capture(2, 10, 7'h7F, 7'h11, 1, 5, -1);

        // start and abort together from IDLE.
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_eq("start_abort_state", {29'b0, dbg_state}, 32'd0);
        check_eq("start_abort_busy", {31'b0, busy}, 32'd0);

        // Masked compare; matches during PRE are ignored.
        fill_seq(7'h7E); seq[0] = 7'h01; seq[1] = 7'h01; seq[2] = 7'h01; seq[5] = 7'h01;
        run_capture(3, 2, 7'h01, 7'h01, 0, 0, -1);

        // Match held across PRE -> ARMED triggers on the first ARMED sample.
        fill_seq(7'h33);
        run_capture(2, 1, 7'h7F, 7'h33, 0, 0, -1);

        // Oversized lengths are clamped to DEPTH-1.
        fill_seq(7'h00);
        run_capture(100, 200, 7'h00, 7'h00, 0, 0, -1);

        // Reset in the middle of POST.
        for (int i = 0; i < 64; i++) seq[i] = DW'($urandom_range(127, 0));
        run_capture(1, 5, 7'h00, 7'h00, 2, 3, -1);

        // Random captures; sample 40 always matches so every capture terminates.
        for (int r = 0; r < 4; r++) begin
            rm = DW'($urandom_range(127, 0));
            rv = DW'($urandom_range(127, 0));
            for (int i = 0; i < 64; i++) seq[i] = DW'($urandom_range(127, 0));
            seq[40] = rv;
            run_capture($urandom_range(5, 0), $urandom_range(5, 0), rm, rv, 0, 0, -1);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cw_capture_ctrl.md
Name: cw_capture_ctrl

Overview:
Capture sequencer for the on-chip signal watcher trace buffer.
- Samples a probe bus on every trig_clk cycle while a capture is in progress.
- Writes each sample to the trace RAM through the wt_ce/wt_en/wt_addr interface, with a data copy aligned to the write strobe.
- Implements a pre-trigger fill, a masked value-compare trigger and a post-trigger count.
- Status outputs let the JTAG-side controller locate the trigger sample in the circular buffer.

Parameters:
DIN_WIDTH, 7, probe bus width.
ADDR_WIDTH, 16, trace address width; matches wt_addr.
DEPTH, 1024, buffer entries; power of two, at most 2^ADDR_WIDTH; addresses wrap modulo DEPTH.

Ports:
trig_clk  in  1  sole clock.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle pulse; begins a capture from IDLE or DONE.
abort  in  1  one-cycle pulse; cancels any capture in progress.
trig_mask  in  DIN_WIDTH  1 = bit participates in the compare.
trig_val  in  DIN_WIDTH  compare value.
pre_len  in  ADDR_WIDTH  samples written before the trigger is armed.
post_len  in  ADDR_WIDTH  samples written after the trigger sample.
bus_din  in  DIN_WIDTH  probe bus.
wt_ce  out  1  trace RAM chip enable.
wt_en  out  1  trace RAM write enable.
wt_addr  out  ADDR_WIDTH  write address.
wt_data  out  DIN_WIDTH  sample aligned with wt_en.
busy  out  1  capture in progress.
triggered  out  1  trigger seen in the current or last capture.
done  out  1  capture completed.
trig_addr  out  ADDR_WIDTH  address at which the trigger sample was written.

Behaviour:
- Clocking and reset: single clock, trig_clk; reset rst is synchronous and active-high. On reset all outputs are 0 and the state is IDLE.
- States: IDLE, PRE, ARMED, POST, DONE. All outputs are registered.
- Write timing: while in PRE, ARMED or POST, every cycle performs a write.
  - wt_ce = wt_en = 1.
  - wt_data = bus_din sampled in the previous cycle.
  - wt_addr advances by 1 modulo DEPTH after each write.
- wt_ce = wt_en = 0 in IDLE and DONE. wt_addr holds its last value.
- Start: start at cycle N in IDLE or DONE gives, at N+1:
  - wt_addr = 0, first write, busy = 1;
  - done and triggered cleared;
  - pre_len and post_len latched; pre_len clamped to DEPTH-1, post_len clamped to DEPTH-1.
  - Next state is PRE if latched pre_len > 0, otherwise ARMED.
- start is ignored while busy.
- PRE: the trigger compare is ignored. After pre_len writes, move to ARMED.
- ARMED: match = ((bus_din ^ trig_val) & trig_mask) == 0, evaluated on the sample being written.
  - On a match: trig_addr = that write's address, triggered = 1, move to POST.
  - If post_len = 0, move directly to DONE, so the trigger sample is the last write.
  - trig_mask = 0 triggers on the first ARMED sample.
  - ARMED continues indefinitely, wrapping the address and overwriting older samples.
- POST: exactly post_len writes after the trigger sample, then DONE.
- DONE: busy = 0, done = 1. done and trig_addr are held until the next start or rst.
- Abort: abort in PRE, ARMED or POST means the next cycle has no write, the state is IDLE, busy = 0 and done = 0. triggered keeps its value.
  - abort and start in the same cycle: abort wins.
  - abort in IDLE or DONE: no effect.
- Reset mid-capture: rst takes effect immediately and returns everything to reset values; the buffer contents are undefined from the controller's view.

Optional Feature:
CW_EDGE_TRIG_EN
- Defined: trigger requires match this cycle AND no match on the previous sample, i.e. a rising edge of the compare. The previous-match register is cleared on entry to ARMED, so a condition already true on the first ARMED sample triggers.
- Undefined: level trigger as described in Behaviour.

Test Plan:
1. Basic capture: pre_len=4, post_len=3, trig_mask=7'h7F, trig_val=7'h55, bus_din=0 then 7'h55 at the 7th sample. Expect PRE at wt_addr 0-3; trigger write at addr 6; trig_addr=6; writes at 7, 8, 9; done=1; exactly 10 wt_en pulses.
2. Wrap-around: DEPTH=16, pre_len=0, trigger after 20 samples. Expect wt_addr sequence ...15,0,1...; trig_addr=4.
3. Immediate trigger and post_len=0: pre_len=0, trig_mask=0. Expect one write at addr 0, trig_addr=0, done the following cycle.
4. Abort: abort during POST. Expect no further wt_en, busy=0, done=0, triggered=1. start+abort in the same cycle from IDLE leaves the state in IDLE.
5. Masking: trig_mask=7'h01, trig_val=7'h01, bus_din=7'h7E then 7'h01. Expect no trigger on 7'h7E, trigger on 7'h01. Trigger conditions during PRE are ignored.
6. Edge mode with CW_EDGE_TRIG_EN: match held high from entry to ARMED. Expect the trigger on the first ARMED sample only. A matching sample held across pre→armed with the macro off triggers on the first ARMED sample as well.
